if_fetch_ctrl: RTL

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

---
 rtl/mips_16_ctrl_pkg.sv | 21 ++
 rtl/sat_counter.sv | 28 ++
 rtl/if_fetch_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mips_16_ctrl_pkg.sv
// Shared definitions for the MIPS-16 pipeline front-end controller.
// Holds the controller state encoding and the widths of the internal
// boot and stall counters so that sibling blocks agree on them.
package mips_16_ctrl_pkg;

  // Boot counter must hold BOOT_WAIT-1 (BOOT_WAIT <= 15).
  localparam int BOOT_CNT_W  = 4;
  // Consecutive-stall counter must hold STALL_LIMIT-1 (STALL_LIMIT <= 255).
  localparam int STALL_CNT_W = 8;
  // Width of the externally visible saturating stall statistic.
  localparam int STALL_CYC_W = 16;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STALL = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, clears the count
//   i_en    : count enable, one increment per enabled cycle
//   o_count : current count, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_full;

  assign w_full  = (r_count == {WIDTH{1'b1}});
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (i_en && !w_full)
      r_count <= r_count + WIDTH'(1);
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch / hazard controller for the MIPS-16 pipeline.
// Registered state, combinational outputs (zero-cycle response to inputs).
//   clk                  : pipeline clock, rising edge
//   rst                  : asynchronous active-low reset
//   hazard_stall         : load-use hazard from ID
//   branch_taken         : branch resolved taken (IF_stage loads target)
//   halt_req             : debug halt request, level
//   resume_req           : debug resume, single-cycle pulse
//   instruction_fetch_en : IF_stage PC/fetch enable
//   if_id_flush          : zero the IF/ID register
//   id_ex_flush          : insert bubble into ID/EX
//   halt_ack             : high while halted
//   stall_err            : sticky stall-limit overflow flag
//   stall_cycles         : saturating count of STALL-state cycles
//   ctrl_state           : current state encoding
module if_fetch_ctrl
  import mips_16_ctrl_pkg::*;
#(
  parameter int BOOT_WAIT   = 2,
  parameter int STALL_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic        halt_req,
  input  logic        resume_req,
  output logic        instruction_fetch_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halt_ack,
  output logic        stall_err,
  output logic [15:0] stall_cycles,
  output logic [2:0]  ctrl_state
);

  localparam logic [BOOT_CNT_W-1:0]  BOOT_LAST  = BOOT_CNT_W'(BOOT_WAIT - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(STALL_LIMIT - 1);

  ctrl_state_e             r_state;
  ctrl_state_e             w_next;
  logic [BOOT_CNT_W-1:0]   r_boot_cnt;
  logic [STALL_CNT_W-1:0]  r_stall_cnt;
  logic                    r_stall_err;
  // Set when leaving HALT by resume while halt_req is still high; blocks a
  // re-halt until halt_req has been seen low.
  logic                    r_halt_blk;

  logic                    w_fetch_en;
  logic                    w_if_id_flush;
  logic                    w_id_ex_flush;
  logic                    w_stall_ovf;
  logic                    w_halt_ok;
  logic                    w_in_stall;

  assign w_halt_ok  = halt_req && !r_halt_blk;
  assign w_in_stall = (r_state == ST_STALL);

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_BOOT;
    else
      r_state <= w_next;
  end

  //--------------------------------------------------------------------------
  // Next state and output decode
  //--------------------------------------------------------------------------
  always_comb begin
    w_next        = r_state;
    w_fetch_en    = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_stall_ovf   = 1'b0;
    case (r_state)
      ST_BOOT: begin
        if (r_boot_cnt == BOOT_LAST)
          w_next = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken) begin
          // PC loads the target this cycle; both younger stages are squashed.
          w_fetch_en    = 1'b1;
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          w_next        = ST_FLUSH;
        end else if (hazard_stall) begin
          w_id_ex_flush = 1'b1;
          w_next        = ST_STALL;
        end else if (w_halt_ok) begin
          w_next = ST_HALT;
        end else begin
          w_fetch_en = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_fetch_en    = 1'b1;
        w_if_id_flush = 1'b1;
        if (branch_taken)
          w_id_ex_flush = 1'b1;  // back-to-back branch: squash again, stay
        else
          w_next = ST_RUN;
      end
      ST_STALL: begin
        w_id_ex_flush = 1'b1;
        if (branch_taken) begin
          w_fetch_en    = 1'b1;
          w_if_id_flush = 1'b1;
          w_next        = ST_FLUSH;
        end else if (!hazard_stall) begin
          w_next = ST_RUN;
        end else if (r_stall_cnt == STALL_LAST) begin
          // This is the STALL_LIMIT-th consecutive stall cycle.
          w_stall_ovf = 1'b1;
          w_next      = ST_HALT;
        end
      end
      ST_HALT: begin
        if (resume_req)
          w_next = ST_RUN;
      end
      default: w_next = ST_BOOT;
    endcase
  end

  //--------------------------------------------------------------------------
  // Boot wait counter: only advances while in BOOT.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_boot_cnt <= '0;
    else if (r_state == ST_BOOT)
      r_boot_cnt <= r_boot_cnt + BOOT_CNT_W'(1);
  end

  //--------------------------------------------------------------------------
  // Consecutive-stall counter: counts STALL cycles, cleared on any exit.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cnt <= '0;
    else if (w_in_stall && (w_next == ST_STALL))
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    else
      r_stall_cnt <= '0;
  end

  //--------------------------------------------------------------------------
  // Sticky overflow flag, reset-only clear.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_err <= 1'b0;
    else if (w_stall_ovf)
      r_stall_err <= 1'b1;
  end

  //--------------------------------------------------------------------------
  // Halt edge tracker.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_halt_blk <= 1'b0;
    else if ((r_state == ST_HALT) && resume_req)
      r_halt_blk <= halt_req;
    else if (!halt_req)
      r_halt_blk <= 1'b0;
  end

  //--------------------------------------------------------------------------
  // Saturating statistic of STALL-state cycles.
  //--------------------------------------------------------------------------
  sat_counter #(
    .WIDTH (STALL_CYC_W)
  ) u_stall_cycles (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (w_in_stall),
    .o_count (stall_cycles)
  );

  assign instruction_fetch_en = w_fetch_en;
  assign if_id_flush          = w_if_id_flush;
  assign id_ex_flush          = w_id_ex_flush;
  assign halt_ack             = (r_state == ST_HALT);
  assign stall_err            = r_stall_err;
  assign ctrl_state           = r_state;

endmodule
